bmem_line_adapter: RTL and testbench
====================================

// Module: bmem_line_adapter
// PURPOSE
//   Cache-side initiator for the banked memory port (bmem_*) that the cpu top exposes to banked_memory.
//   Converts one cache-line request (read fill or dirty writeback) from the cache arbiter into a
//   BURST_LEN-beat bmem transaction, then returns a single-cycle dfp_resp with the assembled line.
//   One transaction in flight at a time; sits between the I/D cache arbiter and the cpu bmem ports.
// PARAMETERS
//   ADDR_W     32  byte-address width of dfp_addr / bmem_addr / bmem_raddr
//   DATA_W     64  bmem beat width in bits
//   BURST_LEN  4   beats per line; line width LINE_W = BURST_LEN*DATA_W (256)
// PORTS
//   clk          in   1        clock
//   rst          in   1        reset: synchronous, active-high
//   dfp_addr     in   ADDR_W   line address from cache; low log2(LINE_W/8) bits ignored
//   dfp_read     in   1        line read request, held until dfp_resp
//   dfp_write    in   1        line write request, held until dfp_resp
//   dfp_wdata    in   LINE_W   writeback line, beat 0 = bits [DATA_W-1:0]
//   dfp_rdata    out  LINE_W   fill line, valid when dfp_resp=1
//   dfp_resp     out  1        one-cycle completion pulse
//   bmem_addr    out  ADDR_W   line-aligned address
//   bmem_read    out  1        read command (one cycle per transaction)
//   bmem_write   out  1        write beat strobe
//   bmem_wdata   out  DATA_W   write beat data
//   bmem_ready   in   1        memory can accept a new command
//   bmem_raddr   in   ADDR_W   address tag of returning read beats
//   bmem_rdata   in   DATA_W   read beat data
//   bmem_rvalid  in   1        read beat valid
//   err          out  1        sticky protocol error (only driven by RADDR_CHECK_EN)
// BEHAVIOUR
//   - Reset: state IDLE, beat_cnt=0; dfp_rdata=0, dfp_resp=0, bmem_addr=0, bmem_read=0,
//     bmem_write=0, bmem_wdata=0, err=0. Reset mid-transaction aborts immediately; no dfp_resp issued.
//   - FSM IDLE -> RD_CMD | WR_BURST -> (RD_WAIT) -> DONE -> IDLE.
//   - IDLE: dfp_write has priority over dfp_read if both high. Latch aligned addr and dfp_wdata.
//   - RD_CMD: bmem_read=1, bmem_addr=line addr; stay until bmem_ready=1 sampled, then RD_WAIT.
//     bmem_read is high for exactly the cycle ready is seen high (plus preceding stall cycles).
//   - RD_WAIT: each bmem_rvalid writes bmem_rdata into slice beat_cnt of line buffer, beat_cnt++;
//     on beat BURST_LEN-1 -> DONE. rvalid gaps allowed; no timeout.
//   - WR_BURST: first beat issued only when bmem_ready=1; once started, BURST_LEN beats on
//     consecutive cycles with bmem_write=1, bmem_addr held, bmem_wdata = slice beat_cnt; ready ignored
//     after beat 0. After last beat -> DONE.
//   - DONE: dfp_resp=1 exactly one cycle; dfp_rdata holds last fill until next fill completes
//     (write completions leave it unchanged). Next state IDLE; requests not sampled in DONE.
//   - Min latency: read = 1 cmd cycle + BURST_LEN beats + 1; write = BURST_LEN + 1 cycles.
//   - bmem_rvalid outside RD_WAIT is ignored. beat_cnt is clog2(BURST_LEN) bits, cleared in IDLE.
// CONFIGURATION
//   RADDR_CHECK_EN defined: in RD_WAIT a beat is accepted only if bmem_raddr == latched line addr;
//     mismatched beats are dropped and set err; rvalid outside RD_WAIT also sets err. err clears only on rst.
//   RADDR_CHECK_EN undefined: bmem_raddr ignored, every rvalid in RD_WAIT accepted, err tied 0.
// TESTING
//   1 read 0x0000_1040, ready=1, 4 rvalid beats 0x11..,0x22..,0x33..,0x44.. back-to-back -> bmem_read 1 cycle
//     addr 0x0000_1040, dfp_resp 1 cycle after beat 4, dfp_rdata = {0x44..,0x33..,0x22..,0x11..}.
//   2 write 0x0000_2000, line {D3,D2,D1,D0}, ready low 3 cycles -> no bmem_write until ready; then D0..D3 on
//     4 consecutive cycles, addr 0x0000_2000, dfp_resp the following cycle.
//   3 read and write asserted together -> write burst first; read serviced after write resp.
//   4 read with rvalid gaps (beats at cycles +3,+4,+9,+12) -> line assembled in order, single resp.
//   5 rst asserted after beat 2 of write -> next cycle all outputs 0, no resp; new read then works.
//   6 RADDR_CHECK_EN: beat with raddr 0x0000_3000 during read of 0x0000_1040 -> dropped, err=1, read still
//     completes on 4 matching beats; undefined: same stimulus accepts the beat, err=0.

Source files
------------

// File: rtl/bmem_line_adapter.sv
// Cache-line initiator for the banked memory port: one line fill or writeback per transaction.
// Optional RADDR_CHECK_EN: read beats filtered by bmem_raddr tag, sticky err on stray/mismatched beats.
module bmem_line_adapter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 4,
    localparam int LINE_W   = BURST_LEN * DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dfp_addr,
    input  logic              dfp_read,
    input  logic              dfp_write,
    input  logic [LINE_W-1:0] dfp_wdata,
    output logic [LINE_W-1:0] dfp_rdata,
    output logic              dfp_resp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [DATA_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [DATA_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid,
    output logic              err
);

    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, WR_BURST, DONE} state_t;

    state_t                           state;
    logic [CNT_W-1:0]                 beat_cnt;
    logic [BURST_LEN-1:0][DATA_W-1:0] wr_line;
    logic [BURST_LEN-1:0][DATA_W-1:0] fill_line;
    logic [BURST_LEN-1:0][DATA_W-1:0] fill_next;
    logic [ADDR_W-1:0]                line_addr;
    logic                             beat_ok;
    logic                             unused_low;

    assign line_addr  = {dfp_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign unused_low = ^dfp_addr[OFF_W-1:0];

    // Beat 0 waits for ready; the rest of the burst streams regardless of ready.
    assign bmem_write = (state == WR_BURST) && ((beat_cnt != '0) || bmem_ready);
    assign bmem_wdata = (state == WR_BURST) ? wr_line[beat_cnt] : '0;

    always_comb begin
        fill_next           = fill_line;
        fill_next[beat_cnt] = bmem_rdata;
    end

`ifdef RADDR_CHECK_EN
    assign beat_ok = bmem_rvalid && (bmem_raddr == bmem_addr);

    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (bmem_rvalid && ((state != RD_WAIT) || (bmem_raddr != bmem_addr)))
            err <= 1'b1;
    end
`else
    logic unused_raddr;
    assign unused_raddr = ^bmem_raddr;
    assign beat_ok      = bmem_rvalid;
    assign err          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            wr_line   <= '0;
            fill_line <= '0;
            dfp_rdata <= '0;
            dfp_resp  <= 1'b0;
            bmem_addr <= '0;
            bmem_read <= 1'b0;
        end else begin
            dfp_resp <= 1'b0;
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (dfp_write) begin
                        bmem_addr <= line_addr;
                        wr_line   <= dfp_wdata;
                        state     <= WR_BURST;
                    end else if (dfp_read) begin
                        bmem_addr <= line_addr;
                        bmem_read <= 1'b1;
                        state     <= RD_CMD;
                    end
                end
                RD_CMD: begin
                    if (bmem_ready) begin
                        bmem_read <= 1'b0;
                        state     <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (beat_ok) begin
                        fill_line <= fill_next;
                        beat_cnt  <= beat_cnt + CNT_W'(1);
                        if (beat_cnt == LAST_BEAT) begin
                            // Publish the line only once complete so dfp_rdata holds the previous fill meanwhile.
                            dfp_rdata <= fill_next;
                            dfp_resp  <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                WR_BURST: begin
                    if (bmem_write) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (beat_cnt == LAST_BEAT) begin
                            dfp_resp <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bmem_line_adapter.sv
// Scoreboard bench for bmem_line_adapter: line-level memory reference model, randomized bmem responder.
module tb_bmem_line_adapter;
    localparam int AW = 32, DW = 64, BL = 4, LW = BL * DW;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] dfp_addr = '0;
    logic          dfp_read = 1'b0, dfp_write = 1'b0;
    logic [LW-1:0] dfp_wdata = '0;
    logic [LW-1:0] dfp_rdata;
    logic          dfp_resp;
    logic [AW-1:0] bmem_addr;
    logic          bmem_read, bmem_write;
    logic [DW-1:0] bmem_wdata;
    logic          bmem_ready = 1'b0;
    logic [AW-1:0] bmem_raddr = '0;
    logic [DW-1:0] bmem_rdata = '0;
    logic          bmem_rvalid = 1'b0;
    logic          err;

    bmem_line_adapter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write), .dfp_wdata(dfp_wdata),
        .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
        .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid),
        .err(err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [LW-1:0] ref_mem [int unsigned];   // what the cache should see
    logic [LW-1:0] mem     [int unsigned];   // what the memory holds
    logic [LW-1:0] last_fill = '0;
    logic [AW-1:0] exp_cmd_q[$];
    beat_t         exp_wbeat_q[$];
    logic [LW-1:0] exp_resp_q[$];
    beat_t         pend_q[$];
    logic [LW-1:0] wr_acc = '0;
    logic [AW-1:0] wr_acc_addr = '0;
    int            wr_acc_n = 0, ready_low_n = 0, wbeats_seen = 0, rd_cycles = 0;
    bit            rand_on = 1'b0, inject_bad = 1'b0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        total++;
        bad++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
        logic [LW-1:0] l;
        for (int b = 0; b < BL; b++) l[b*DW +: DW] = {a, a ^ 32'h5A5A_0000 ^ 32'(b)};
        return l;
    endfunction

    function automatic logic [LW-1:0] ref_line(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
    endfunction

    function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : init_line(a);
    endfunction

    // Memory responder plus monitors for commands, write beats and responses.
    always begin
        beat_t b;
        logic [LW-1:0] line;
        @(negedge clk);
        bmem_rvalid = 1'b0;
        bmem_rdata  = rand_on ? {$urandom, $urandom} : '0;
        if (pend_q.size() > 0 && (!rand_on || $urandom_range(3) != 0)) begin
            b = pend_q.pop_front();
            bmem_rvalid = 1'b1;
            bmem_raddr  = b.addr;
            bmem_rdata  = b.data;
        end else if (pend_q.size() == 0 && rand_on) begin
`ifndef RADDR_CHECK_EN
            bmem_rvalid = ($urandom_range(7) == 0);
            bmem_raddr  = $urandom;
`endif
        end
        if (ready_low_n > 0) begin
            bmem_ready = 1'b0;
            ready_low_n--;
        end else begin
            bmem_ready = rand_on ? ($urandom_range(3) != 0) : 1'b1;
        end
        #1;
        if (bmem_read) rd_cycles++;
        if (bmem_read && bmem_ready) begin
            if (exp_cmd_q.size() == 0) miss("cmd_unexpected");
            else chk("cmd_addr", bmem_addr, exp_cmd_q.pop_front());
            line = mem_line(bmem_addr);
            if (inject_bad) begin
                b.addr = 32'h0000_3000;
                b.data = 64'hBAD0_BAD0_BAD0_BAD0;
                pend_q.push_back(b);
                inject_bad = 1'b0;
            end
            for (int i = 0; i < BL; i++) begin
                b.addr = bmem_addr;
`ifndef RADDR_CHECK_EN
                if (rand_on && $urandom_range(1) == 0) b.addr = $urandom;
`endif
                b.data = line[i*DW +: DW];
                pend_q.push_back(b);
            end
        end
        if (bmem_write) begin
            if (wr_acc_n == 0 && !bmem_ready) miss("write_without_ready");
            if (exp_wbeat_q.size() == 0) miss("write_unexpected");
            else begin
                b = exp_wbeat_q.pop_front();
                chk("wbeat_addr", bmem_addr, b.addr);
                chk("wbeat_data", bmem_wdata, b.data);
            end
            if (wr_acc_n == 0) wr_acc_addr = bmem_addr;
            wr_acc[wr_acc_n*DW +: DW] = bmem_wdata;
            wr_acc_n++;
            wbeats_seen++;
            if (wr_acc_n == BL) begin
                mem[wr_acc_addr] = wr_acc;
                wr_acc_n = 0;
            end
        end else if (wr_acc_n != 0) begin
            miss("write_burst_gap");
        end
        if (dfp_resp) begin
            if (exp_resp_q.size() == 0) miss("resp_unexpected");
            else chk("resp_rdata", dfp_rdata, exp_resp_q.pop_front());
        end
    end

    task automatic do_req(input bit rd, input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] wdata,
                          input bit ovr, input logic [LW-1:0] ovr_line, output int lat);
        logic [AW-1:0] a;
        beat_t b;
        int left;
        a = addr & ~32'h1F;
        @(negedge clk);
        if (wr) begin
            for (int i = 0; i < BL; i++) begin
                b.addr = a;
                b.data = wdata[i*DW +: DW];
                exp_wbeat_q.push_back(b);
            end
            exp_resp_q.push_back(last_fill);
            ref_mem[a] = wdata;
        end
        if (rd) begin
            exp_cmd_q.push_back(a);
            last_fill = ovr ? ovr_line : ref_line(a);
            exp_resp_q.push_back(last_fill);
        end
        dfp_addr = addr; dfp_read = rd; dfp_write = wr; dfp_wdata = wdata;
        left = int'(rd) + int'(wr);
        lat = 0;
        while (left > 0 && lat < 400) begin
            @(negedge clk);
            lat++;
            if (dfp_resp) begin
                left--;
                dfp_write = 1'b0;
                if (left == 0) dfp_read = 1'b0;
            end
        end
        if (left > 0) begin
            miss("resp_timeout");
            dfp_read = 1'b0;
            dfp_write = 1'b0;
        end
    endtask

    task automatic check_idle(input string name);
        chk({name, "_rdata"}, dfp_rdata, '0);
        chk({name, "_ctl"}, {dfp_resp, bmem_read, bmem_write, err, bmem_addr, bmem_wdata}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, rc0;
        logic [LW-1:0] l1, exp6, wd;
        logic [AW-1:0] ra;
        bit r, w;

        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        // Back-to-back fill with known beats
        l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        mem[32'h1040] = l1;
        ref_mem[32'h1040] = l1;
        rc0 = rd_cycles;
        do_req(1'b1, 1'b0, 32'h0000_1040, '0, 1'b0, '0, lat);
        chk("t1_latency", lat, 6);
        chk("t1_read_cycles", rd_cycles - rc0, 1);

        // Writeback stalled on ready
        @(negedge clk); #3 ready_low_n = 4;
        wd = {64'hD3D3_D3D3_0000_0003, 64'hD2D2_D2D2_0000_0002,
              64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000};
        do_req(1'b0, 1'b1, 32'h0000_2000, wd, 1'b0, '0, lat);
        chk("t2_latency", lat, 8);

        // Stray-tag beat in the middle of a fill
        @(negedge clk); #3 inject_bad = 1'b1;
`ifdef RADDR_CHECK_EN
        exp6 = l1;
`else
        exp6 = {l1[191:0], 64'hBAD0_BAD0_BAD0_BAD0};
`endif
        do_req(1'b1, 1'b0, 32'h0000_1040, '0, 1'b1, exp6, lat);
        repeat (2) @(negedge clk);
`ifdef RADDR_CHECK_EN
        chk("t6_err", err, 1);
`else
        chk("t6_err", err, 0);
`endif

        // Simultaneous write and read of the same line: write must land first
        for (int i = 0; i < BL; i++) wd[i*DW +: DW] = {$urandom, $urandom};
        do_req(1'b1, 1'b1, 32'h0000_2045, wd, 1'b0, '0, lat);

        // Random traffic with ready stalls, rvalid gaps and stray beats
        @(negedge clk); #3 rand_on = 1'b1;
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(5))
                0, 1, 2: begin r = 1'b1; w = 1'b0; end
                3, 4:    begin r = 1'b0; w = 1'b1; end
                default: begin r = 1'b1; w = 1'b1; end
            endcase
            ra = 32'h8000 + ($urandom_range(15) << 5) + $urandom_range(31);
            for (int i = 0; i < BL; i++) wd[i*DW +: DW] = {$urandom, $urandom};
            do_req(r, w, ra, wd, 1'b0, '0, lat);
            repeat ($urandom_range(2)) @(negedge clk);
        end
        @(negedge clk); #3 rand_on = 1'b0;

        // Reset in the middle of a writeback
        ra = 32'h0000_4000;
        for (int i = 0; i < BL; i++) wd[i*DW +: DW] = {$urandom, $urandom};
        @(negedge clk);
        for (int i = 0; i < BL; i++) begin
            exp_wbeat_q.push_back('{addr: ra, data: wd[i*DW +: DW]});
        end
        dfp_addr = ra; dfp_write = 1'b1; dfp_wdata = wd;
        rc0 = wbeats_seen;
        lat = 0;
        while (wbeats_seen - rc0 < 2 && lat < 50) begin
            @(negedge clk); #2;
            lat++;
        end
        if (lat >= 50) miss("t5_timeout");
        rst = 1'b1;
        @(posedge clk); #1;
        exp_wbeat_q.delete(); exp_cmd_q.delete(); exp_resp_q.delete(); pend_q.delete();
        wr_acc_n = 0;
        last_fill = '0;
        dfp_write = 1'b0;
        @(negedge clk);
        check_idle("t5_after_rst");
        rst = 1'b0;

        do_req(1'b1, 1'b0, 32'h0000_1040, '0, 1'b0, '0, lat);
        chk("t5_read_latency", lat, 6);

        repeat (5) @(negedge clk);
        chk("queues_drained", exp_resp_q.size() + exp_cmd_q.size() + exp_wbeat_q.size(), 0);
        chk("err_final", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
